// File: rtl/dino_pkg.sv
// Shared types and map geometry for the side-scrolling game datapath.
package dino_pkg;

    localparam int unsigned MAP_ROW_BYTES = 512;
    localparam int unsigned SCREEN_BYTES  = 80;
    localparam int unsigned MAX_SPEED     = 4;
    // Last legal pixel scroll position: the screen's right edge sits on the row's last byte.
    localparam int unsigned END_PIX       = (MAP_ROW_BYTES - SCREEN_BYTES) * 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSED  = 3'd2,
        CRASHED = 3'd3,
        CLEARED = 3'd4
    } game_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered one-cycle rising-edge pulse.
// The pulse is only armed once a valid low has been observed after reset, so an input
// that is already high when reset releases does not produce a spurious edge.
module sync_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic i_async,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_v1;
    logic r_v2;
    logic r_armed;
    logic r_pulse;

    // Synchronize, track when r_s2 holds real input data, and form the edge pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_async;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_v1    <= 1'b1;
            r_v2    <= r_v1;
            r_armed <= r_armed | (r_v2 & ~r_s2);
            r_pulse <= r_armed & r_s2 & ~r_s3;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/map_scroller.sv
// Horizontal map scroll controller: game FSM, speed ramp and clamped pixel position.
module map_scroller
    import dino_pkg::*;
#(
    parameter int unsigned MAP_ROW_BYTES = dino_pkg::MAP_ROW_BYTES,
    parameter int unsigned SCREEN_BYTES  = dino_pkg::SCREEN_BYTES,
    parameter int unsigned MAX_SPEED     = dino_pkg::MAX_SPEED,
    parameter int unsigned RAMP_FRAMES   = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        pause,
    input  logic        collision,
    output logic [9:0]  shifted_x,
    output logic [2:0]  fine_x,
    output logic [2:0]  speed,
    output game_state_t game_state,
    output logic        frame_tick
);

    localparam logic [12:0] LIMIT_PIX = 13'((MAP_ROW_BYTES - SCREEN_BYTES) * 8);
    localparam logic [2:0]  SPEED_MAX = 3'(MAX_SPEED);
    localparam int unsigned RAMP_W    = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);

    logic              w_frame_tick;
    logic              w_start_evt;
    logic              w_pause_evt;
    logic [13:0]       w_pos_sum;
    logic [12:0]       w_pos_next;
    logic [2:0]        w_speed_next;

    game_state_t       r_state;
    logic [12:0]       r_pos;
    logic [2:0]        r_speed;
    logic [RAMP_W-1:0] r_ramp;

    sync_edge u_sync_frame (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_async (frame_clk),
        .o_pulse (w_frame_tick)
    );

    sync_edge u_sync_start (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_async (start),
        .o_pulse (w_start_evt)
    );

    sync_edge u_sync_pause (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_async (pause),
        .o_pulse (w_pause_evt)
    );

    // Clamping here keeps shifted_x inside the row for any speed/END combination.
    assign w_pos_sum    = {1'b0, r_pos} + 14'(r_speed);
    assign w_pos_next   = (w_pos_sum >= {1'b0, LIMIT_PIX}) ? LIMIT_PIX : w_pos_sum[12:0];
    assign w_speed_next = (r_speed < SPEED_MAX) ? r_speed + 3'd1 : r_speed;

    // Game FSM together with the position, speed and ramp registers it owns.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_speed <= 3'd1;
            r_ramp  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_pos   <= '0;
                    r_speed <= 3'd1;
                    r_ramp  <= '0;
                    if (w_start_evt) r_state <= RUN;
                end
                RUN: begin
                    // Pause beats a coincident tick; collision beats reaching the end.
                    if (w_pause_evt) begin
                        r_state <= PAUSED;
                    end else if (w_frame_tick) begin
                        if (collision) begin
                            r_state <= CRASHED;
                        end else begin
                            r_pos  <= w_pos_next;
                            r_ramp <= r_ramp + RAMP_W'(1);
                            if (r_ramp == RAMP_LAST) r_speed <= w_speed_next;
                            if (w_pos_next == LIMIT_PIX) r_state <= CLEARED;
                        end
                    end
                end
                PAUSED: begin
                    if (w_pause_evt) r_state <= RUN;
                end
                CRASHED, CLEARED: begin
                    // Restart lands in IDLE with fresh values already in place.
                    if (w_start_evt) begin
                        r_state <= IDLE;
                        r_pos   <= '0;
                        r_speed <= 3'd1;
                        r_ramp  <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign shifted_x  = r_pos[12:3];
    assign fine_x     = r_pos[2:0];
    assign speed      = r_speed;
    assign game_state = r_state;
    assign frame_tick = w_frame_tick;

endmodule

// File: tb/tb_map_scroller.sv
// Directed bench for map_scroller: a default-size instance plus a tiny map instance
// whose end position is not a multiple of the speed, so the clamp is exercised.
module tb_map_scroller;
    import dino_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic        start;
    logic        start_s;
    logic        pause;
    logic        collision;

    logic [9:0]  shifted_x;
    logic [2:0]  fine_x;
    logic [2:0]  speed;
    game_state_t game_state;
    logic        frame_tick;

    logic [9:0]  s_shifted_x;
    logic [2:0]  s_fine_x;
    logic [2:0]  s_speed;
    game_state_t s_game_state;
    logic        s_frame_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ticks_seen;

    map_scroller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .start      (start),
        .pause      (pause),
        .collision  (collision),
        .shifted_x  (shifted_x),
        .fine_x     (fine_x),
        .speed      (speed),
        .game_state (game_state),
        .frame_tick (frame_tick)
    );

    // END = 8 px, speed ramps every 2 frames up to 3: positions 1,2,4,6,then 9 clamps to 8.
    map_scroller #(
        .MAP_ROW_BYTES (81),
        .SCREEN_BYTES  (80),
        .MAX_SPEED     (3),
        .RAMP_FRAMES   (2)
    ) dut_s (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .start      (start_s),
        .pause      (pause),
        .collision  (collision),
        .shifted_x  (s_shifted_x),
        .fine_x     (s_fine_x),
        .speed      (s_speed),
        .game_state (s_game_state),
        .frame_tick (s_frame_tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start();
        @(negedge Clk) start = 1'b1;
        repeat (4) @(negedge Clk);
        start = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic press_start_s();
        @(negedge Clk) start_s = 1'b1;
        repeat (4) @(negedge Clk);
        start_s = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic press_pause();
        @(negedge Clk) pause = 1'b1;
        repeat (4) @(negedge Clk);
        pause = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic check_pos(input string tag, input logic [9:0] sx, input logic [2:0] fx,
                             input logic [2:0] sp, input game_state_t st);
        check({tag, "_sx"}, 16'(shifted_x), 16'(sx));
        check({tag, "_fx"}, 16'(fine_x), 16'(fx));
        check({tag, "_spd"}, 16'(speed), 16'(sp));
        check({tag, "_st"}, 16'(game_state), 16'(st));
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        start     = 1'b0;
        start_s   = 1'b0;
        pause     = 1'b0;
        collision = 1'b0;
        repeat (3) @(negedge Clk);
        check_pos("reset", 10'd0, 3'd0, 3'd1, IDLE);
        check("reset_tick", 16'(frame_tick), 16'd0);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        // Small map: clamp to END and speed ceiling.
        press_start_s();
        check("small_start_st", 16'(s_game_state), 16'(RUN));
        ticks(3);
        check("small_t3_fx", 16'(s_fine_x), 16'd4);
        check("small_t3_spd", 16'(s_speed), 16'd2);
        ticks(2);
        check("small_clr_st", 16'(s_game_state), 16'(CLEARED));
        check("small_clr_sx", 16'(s_shifted_x), 16'd1);
        check("small_clr_fx", 16'(s_fine_x), 16'd0);
        check("small_clr_spd", 16'(s_speed), 16'd3);
        check("idle_hold_sx", 16'(shifted_x), 16'd0);

        // Start, 10 frames at speed 1.
        press_start();
        check("start_st", 16'(game_state), 16'(RUN));
        ticks(10);
        check_pos("run10", 10'd1, 3'd2, 3'd1, RUN);

        // Speed steps on frame 256.
        ticks(245);
        check_pos("run255", 10'd31, 3'd7, 3'd1, RUN);
        tick();
        check_pos("run256", 10'd32, 3'd0, 3'd2, RUN);

        // Pause coincident with a frame tick: pause wins, no position update.
        @(negedge Clk);
        frame_clk = 1'b1;
        pause     = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        pause     = 1'b0;
        repeat (3) @(negedge Clk);
        check_pos("pause", 10'd32, 3'd0, 3'd2, PAUSED);
        ticks(5);
        check_pos("paused5", 10'd32, 3'd0, 3'd2, PAUSED);
        press_start();
        check("paused_start_ign", 16'(game_state), 16'(PAUSED));
        press_pause();
        check("resume_st", 16'(game_state), 16'(RUN));
        tick();
        check_pos("resume_t", 10'd32, 3'd2, 3'd2, RUN);

        // Frames 258..1024: 256+512+768+1024 = 2560 px, speed capped at 4.
        ticks(767);
        check_pos("run1024", 10'd320, 3'd0, 3'd4, RUN);
        ticks(223);
        check_pos("run1247", 10'd431, 3'd4, 3'd4, RUN);

        // Collision on the tick that would reach END.
        collision = 1'b1;
        tick();
        check_pos("crash", 10'd431, 3'd4, 3'd4, CRASHED);
        press_pause();
        check("crash_pause_ign", 16'(game_state), 16'(CRASHED));
        collision = 1'b0;
        press_start();
        check_pos("restart", 10'd0, 3'd0, 3'd1, IDLE);

        // Full run to the end of the map.
        press_start();
        ticks(1248);
        check_pos("clear", 10'd432, 3'd0, 3'd4, CLEARED);
        tick();
        check("clear_frozen_sx", 16'(shifted_x), 16'd432);

        // Reset mid-RUN while frame_clk is held high.
        press_start();
        press_start();
        ticks(3);
        check_pos("prerst", 10'd0, 3'd3, 3'd1, RUN);
        @(negedge Clk) frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        check("prerst_fx", 16'(fine_x), 16'd4);
        Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        check_pos("midrst", 10'd0, 3'd0, 3'd1, IDLE);
        check("midrst_tick", 16'(frame_tick), 16'd0);
        n_ticks_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (frame_tick) n_ticks_seen++;
        end
        check("postrst_no_tick", 16'(n_ticks_seen), 16'd0);
        check("postrst_st", 16'(game_state), 16'(IDLE));
        @(negedge Clk) frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        press_start();
        @(negedge Clk) frame_clk = 1'b1;
        n_ticks_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (frame_tick) n_ticks_seen++;
        end
        check("postrst_one_tick", 16'(n_ticks_seen), 16'd1);
        check_pos("postrst_run", 10'd0, 3'd1, 3'd1, RUN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
